// File: rtl/present_round_ctrl.sv
// Iterative PRESENT-80 encryption core: one round per clock, 31 rounds plus
// final key whitening, one block in flight at a time.
//
// state | meaning
// IDLE  | waiting for Start_i; Data_ob holds the last ciphertext
// RUN   | one data_update and one key-schedule step per cycle
// FIN   | final whitening with K32, Done_o pulse, back to IDLE
module present_round_ctrl #(
  parameter int ROUNDS = 31
) (
  input  logic        Clk_ik,
  input  logic        Rst_irn,
  input  logic        Start_i,
  input  logic [63:0] Data_ib,
  input  logic [79:0] Key_ib,
  output logic        Busy_o,
  output logic        Done_o,
  output logic [63:0] Data_ob
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} fsm_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  fsm_t        fsmState;
  logic [63:0] cipherState;
  logic [79:0] keyReg;
  logic [4:0]  roundCnt;

  function automatic logic [3:0] sBox(input logic [3:0] x);
    case (x)
      4'h0: sBox = 4'hC;
      4'h1: sBox = 4'h5;
      4'h2: sBox = 4'h6;
      4'h3: sBox = 4'hB;
      4'h4: sBox = 4'h9;
      4'h5: sBox = 4'h0;
      4'h6: sBox = 4'hA;
      4'h7: sBox = 4'hD;
      4'h8: sBox = 4'h3;
      4'h9: sBox = 4'hE;
      4'hA: sBox = 4'hF;
      4'hB: sBox = 4'h8;
      4'hC: sBox = 4'h4;
      4'hD: sBox = 4'h7;
      4'hE: sBox = 4'h1;
      default: sBox = 4'h2;
    endcase
  endfunction

  // AddRoundKey, sBoxLayer, then pLayer (bit i moves to i*16 mod 63, bit 63 fixed).
  function automatic logic [63:0] dataUpdate(input logic [63:0] s, input logic [63:0] rk);
    logic [63:0] x;
    logic [63:0] y;
    x = s ^ rk;
    for (int n = 0; n < 16; n++) begin
      x[n*4 +: 4] = sBox(x[n*4 +: 4]);
    end
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[(i * 16) % 63] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [79:0] keySchedule(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sBox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  always_ff @(posedge Clk_ik or negedge Rst_irn) begin
    if (!Rst_irn) begin
      fsmState    <= IDLE;
      cipherState <= '0;
      keyReg      <= '0;
      roundCnt    <= '0;
      Busy_o      <= 1'b0;
      Done_o      <= 1'b0;
      Data_ob     <= '0;
    end else begin
      Done_o <= 1'b0;
      case (fsmState)
        IDLE: begin
          if (Start_i) begin
            cipherState <= Data_ib;
            keyReg      <= Key_ib;
            roundCnt    <= 5'd1;
            Busy_o      <= 1'b1;
            fsmState    <= RUN;
          end
        end
        RUN: begin
          cipherState <= dataUpdate(cipherState, keyReg[79:16]);
          keyReg      <= keySchedule(keyReg, roundCnt);
          roundCnt    <= roundCnt + 5'd1;
          if (roundCnt == LAST_ROUND) begin
            fsmState <= FIN;
          end
        end
        FIN: begin
          Data_ob  <= cipherState ^ keyReg[79:16];
          Done_o   <= 1'b1;
          Busy_o   <= 1'b0;
          fsmState <= IDLE;
        end
        default: fsmState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_round_ctrl.sv
// Directed bench for present_round_ctrl using published PRESENT-80 vectors,
// latency/handshake checks, ignored-Start, back-to-back and async abort cases.
module tb_present_round_ctrl;

  logic        Clk_ik = 1'b0;
  logic        Rst_irn = 1'b0;
  logic        Start_i = 1'b0;
  logic [63:0] Data_ib = '0;
  logic [79:0] Key_ib = '0;
  logic        Busy_o;
  logic        Done_o;
  logic [63:0] Data_ob;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] CT_00 = 64'h5579C1387B228445;
  localparam logic [63:0] CT_0F = 64'hE72C46C0F5945049;
  localparam logic [63:0] CT_F0 = 64'hA112FFC72F68417B;
  localparam logic [63:0] CT_FF = 64'h3333DCD3213210D2;
  localparam logic [79:0] K_ONES = {80{1'b1}};
  localparam logic [63:0] D_ONES = {64{1'b1}};

  present_round_ctrl #(.ROUNDS(31)) dut (
    .Clk_ik(Clk_ik), .Rst_irn(Rst_irn), .Start_i(Start_i),
    .Data_ib(Data_ib), .Key_ib(Key_ib),
    .Busy_o(Busy_o), .Done_o(Done_o), .Data_ob(Data_ob)
  );

  always #5 Clk_ik = ~Clk_ik;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle Start, optionally poke a stray Start mid-run, and check
  // latency, Busy_o coverage, Done_o count and ciphertext.
  task automatic encrypt(input string tag, input logic [63:0] d, input logic [79:0] k,
                         input logic [63:0] exp, input bit strayStart);
    int doneAt;
    int busyLow;
    int doneCount;
    @(negedge Clk_ik);
    Data_ib = d;
    Key_ib = k;
    Start_i = 1'b1;
    @(posedge Clk_ik);
    #1;
    Start_i = 1'b0;
    Data_ib = ~d;
    Key_ib = ~k;
    doneAt = -1;
    busyLow = 0;
    doneCount = 0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (strayStart && cyc == 10) begin
        Data_ib = '0;
        Key_ib = '0;
        Start_i = 1'b1;
      end
      if (strayStart && cyc == 11) Start_i = 1'b0;
      @(posedge Clk_ik);
      #1;
      if (Done_o) begin
        doneCount++;
        if (doneAt < 0) doneAt = cyc;
      end
      if (doneAt < 0 && !Busy_o) busyLow++;
      if (doneAt > 0 && !strayStart) break;
    end
    check({tag, " latency"}, 64'(doneAt), 64'd32);
    check({tag, " busy-before-done"}, 64'(busyLow), 64'd0);
    check({tag, " data"}, Data_ob, exp);
    check({tag, " busy-after"}, 64'(Busy_o), 64'd0);
    if (strayStart) check({tag, " done-count"}, 64'(doneCount), 64'd1);
  endtask

  initial begin
    int cnt;
    int doneTimes [3];
    logic [63:0] held;
    logic [63:0] expQ [3];
    logic [63:0] dQ [3];
    logic [79:0] kQ [3];
    int unstable;
    int idx;

    #12;
    check("reset busy", 64'(Busy_o), 64'd0);
    check("reset done", 64'(Done_o), 64'd0);
    check("reset data", Data_ob, 64'd0);
    @(negedge Clk_ik);
    Rst_irn = 1'b1;

    encrypt("v00", 64'd0, 80'd0, CT_00, 1'b0);
    encrypt("v0F", 64'd0, K_ONES, CT_0F, 1'b0);
    encrypt("vF0", D_ONES, 80'd0, CT_F0, 1'b0);
    encrypt("vFF-stray", D_ONES, K_ONES, CT_FF, 1'b1);

    // Back-to-back with Start held high; new vector presented in each Done cycle.
    dQ = '{64'd0, 64'd0, D_ONES};
    kQ = '{80'd0, K_ONES, 80'd0};
    expQ = '{CT_00, CT_0F, CT_F0};
    @(negedge Clk_ik);
    Data_ib = dQ[0];
    Key_ib = kQ[0];
    Start_i = 1'b1;
    @(posedge Clk_ik);
    #1;
    idx = 0;
    unstable = 0;
    held = Data_ob;
    doneTimes = '{-1, -1, -1};
    for (int cyc = 1; cyc <= 120 && idx < 3; cyc++) begin
      @(posedge Clk_ik);
      #1;
      if (Done_o) begin
        doneTimes[idx] = cyc;
        check($sformatf("b2b data%0d", idx), Data_ob, expQ[idx]);
        held = Data_ob;
        idx++;
        if (idx < 3) begin
          Data_ib = dQ[idx];
          Key_ib = kQ[idx];
        end else begin
          Start_i = 1'b0;
        end
      end else if (Data_ob !== held) begin
        unstable++;
      end
    end
    Start_i = 1'b0;
    check("b2b done0", 64'(doneTimes[0]), 64'd32);
    check("b2b done1", 64'(doneTimes[1]), 64'd65);
    check("b2b done2", 64'(doneTimes[2]), 64'd98);
    check("b2b stable", 64'(unstable), 64'd0);

    // Asynchronous abort at round 15.
    @(negedge Clk_ik);
    Data_ib = '0;
    Key_ib = '0;
    Start_i = 1'b1;
    @(posedge Clk_ik);
    #1;
    Start_i = 1'b0;
    repeat (15) @(posedge Clk_ik);
    #2;
    Rst_irn = 1'b0;
    #1;
    check("abort busy", 64'(Busy_o), 64'd0);
    check("abort done", 64'(Done_o), 64'd0);
    check("abort data", Data_ob, 64'd0);
    @(negedge Clk_ik);
    Rst_irn = 1'b1;
    cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge Clk_ik);
      #1;
      if (Done_o || Busy_o) cnt++;
    end
    check("abort no-done", 64'(cnt), 64'd0);
    encrypt("after-abort", 64'd0, 80'd0, CT_00, 1'b0);

    // Idle hold for 100 cycles.
    cnt = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge Clk_ik);
      #1;
      if (Busy_o !== 1'b0 || Done_o !== 1'b0 || Data_ob !== CT_00) cnt++;
    end
    check("idle hold", 64'(cnt), 64'd0);
    check("idle data", Data_ob, CT_00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
